// File: rtl/theta_slice_engine.sv
// theta_slice_engine: slice-serial Keccak theta step.
// Takes one 25-bit slice per handshake (z = 0..LANE_W-1). Each result is
// emitted one cycle after its input. Slice 0 is held back until the column
// parity of slice LANE_W-1 is known, so the output order is 1..LANE_W-1, 0.
// Build option: define THETA_PARITY_OUT_EN to expose the registered D vector on out_d.
module theta_slice_engine #(
    parameter int LANE_W = 64,
    parameter int ZW     = $clog2(LANE_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [24:0]   in_slice,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [24:0]   out_slice,
    output logic [ZW-1:0] out_z,
    output logic          frame_done
`ifdef THETA_PARITY_OUT_EN
    ,
    output logic [4:0]    out_d
`endif
);

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_STREAM = 2'd1,
        S_LAST   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [ZW-1:0] Z_LAST = ZW'(LANE_W - 1);

    // Column parity C[x] = XOR of the five bits of column x in one slice.
    function automatic logic [4:0] col_parity(input logic [24:0] s);
        logic [4:0] c;
        for (int x = 0; x < 5; x++) begin
            c[x] = s[x] ^ s[5+x] ^ s[10+x] ^ s[15+x] ^ s[20+x];
        end
        return c;
    endfunction

    // D[x] = C_cur[x-1] ^ C_prev[x+1]; C_prev belongs to slice z-1.
    function automatic logic [4:0] theta_d(input logic [4:0] c_cur, input logic [4:0] c_prev);
        logic [4:0] d;
        for (int x = 0; x < 5; x++) begin
            d[x] = c_cur[(x + 4) % 5] ^ c_prev[(x + 1) % 5];
        end
        return d;
    endfunction

    // Replicate the 5-bit D vector across all five rows of a slice.
    function automatic logic [24:0] expand_d(input logic [4:0] d);
        logic [24:0] e;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                e[5*y + x] = d[x];
            end
        end
        return e;
    endfunction

    state_t        state_q, state_d;
    logic [ZW-1:0] z_q, z_d;
    logic [24:0]   hold0_q, hold0_d;
    logic [4:0]    c0_q, c0_d;
    logic [4:0]    cprev_q, cprev_d;
    logic          out_valid_q, out_valid_d;
    logic [24:0]   out_slice_q, out_slice_d;
    logic [ZW-1:0] out_z_q, out_z_d;
`ifdef THETA_PARITY_OUT_EN
    logic [4:0]    out_d_q, out_d_d;
`endif

    logic          slot_free;
    logic          in_ready_c;
    logic          frame_done_c;
    logic [4:0]    c_in;
    logic [4:0]    d_in;
    logic [4:0]    d_last;

    assign slot_free = !out_valid_q || out_ready;
    assign c_in      = col_parity(in_slice);
    assign d_in      = theta_d(c_in, cprev_q);
    assign d_last    = theta_d(c0_q, cprev_q);

    // Next-state, datapath loads and handshake outputs.
    always_comb begin
        state_d      = state_q;
        z_d          = z_q;
        hold0_d      = hold0_q;
        c0_d         = c0_q;
        cprev_d      = cprev_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_slice_d  = out_slice_q;
        out_z_d      = out_z_q;
`ifdef THETA_PARITY_OUT_EN
        out_d_d      = out_d_q;
`endif
        in_ready_c   = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            S_FIRST: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    hold0_d = in_slice;
                    c0_d    = c_in;
                    cprev_d = c_in;
                    z_d     = ZW'(1);
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready_c = slot_free;
                if (in_valid && slot_free) begin
                    out_slice_d = in_slice ^ expand_d(d_in);
                    out_z_d     = z_q;
                    out_valid_d = 1'b1;
                    cprev_d     = c_in;
`ifdef THETA_PARITY_OUT_EN
                    out_d_d     = d_in;
`endif
                    if (z_q == Z_LAST) begin
                        state_d = S_LAST;
                    end else begin
                        z_d = z_q + ZW'(1);
                    end
                end
            end
            S_LAST: begin
                if (slot_free) begin
                    out_slice_d = hold0_q ^ expand_d(d_last);
                    out_z_d     = '0;
                    out_valid_d = 1'b1;
`ifdef THETA_PARITY_OUT_EN
                    out_d_d     = d_last;
`endif
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    frame_done_c = 1'b1;
                    z_d          = '0;
                    state_d      = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    // State, counter, holding and output-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FIRST;
            z_q         <= '0;
            hold0_q     <= '0;
            c0_q        <= '0;
            cprev_q     <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            out_z_q     <= '0;
`ifdef THETA_PARITY_OUT_EN
            out_d_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            hold0_q     <= hold0_d;
            c0_q        <= c0_d;
            cprev_q     <= cprev_d;
            out_valid_q <= out_valid_d;
            out_slice_q <= out_slice_d;
            out_z_q     <= out_z_d;
`ifdef THETA_PARITY_OUT_EN
            out_d_q     <= out_d_d;
`endif
        end
    end

    // No input is accepted while reset is held.
    assign in_ready   = in_ready_c && !rst;
    assign out_valid  = out_valid_q;
    assign out_slice  = out_slice_q;
    assign out_z      = out_z_q;
    assign frame_done = frame_done_c;
`ifdef THETA_PARITY_OUT_EN
    assign out_d      = out_d_q;
`endif

endmodule
